// File: rtl/adc_reader_if.sv
// Bundles the ADC request/ready/data link and the downstream sample stream.
// The master modport is the reader's view; the slave modport is the ADC plus consumer side.
interface adc_reader_if #(
    parameter int DATA_W = 8
) ();
    logic              adc_req;
    logic              adc_rdy;
    logic [DATA_W-1:0] adc_dat;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output adc_req,
        input  adc_rdy,
        input  adc_dat,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  adc_req,
        output adc_rdy,
        output adc_dat,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/adc_reader.sv
// Periodic initiator for an asynchronous request/ready ADC.
// Each captured sample is queued in a small FWFT FIFO drained over a valid/ready stream.
module adc_reader #(
    parameter int DATA_W         = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int REQ_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int PERIOD_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [PERIOD_W-1:0]           period,
    input  logic                          clear_err,
    adc_reader_if.master                  bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          timeout_err,
    output logic                          overflow_err,
    output logic [15:0]                   sample_cnt
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int RCW = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [RCW-1:0] REQ_LAST = RCW'(REQ_CYCLES - 1);
    localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RDY,
        CAPTURE,
        WAIT_PERIOD
    } stateType;

    stateType state;
    stateType nextState;
    stateType afterConv;

    logic                rdyMeta;
    logic                rdyS;
    logic                rdyPrev;
    logic                rdyRise;
    logic [RCW-1:0]      reqCnt;
    logic [TCW-1:0]      waitCnt;
    logic [PERIOD_W-1:0] periodCnt;
    logic [PERIOD_W-1:0] periodLimit;
    logic                periodDone;

    logic [DATA_W-1:0]   fifoMem [FIFO_DEPTH];
    logic [AW-1:0]       wrPtr;
    logic [AW-1:0]       rdPtr;
    logic                outValid;
    logic                fifoFull;
    logic                doPush;
    logic                doPop;
    logic                dropSample;
    logic                timeoutHit;

    assign rdyRise     = rdyS & ~rdyPrev;
    assign periodLimit = (period == '0) ? '0 : period - 1'b1;
    assign periodDone  = (periodCnt >= periodLimit);
    assign outValid    = (fifo_count != '0);
    assign fifoFull    = (fifo_count == FULL_CNT);
    assign doPop       = outValid & bus.out_ready;
    assign busy        = (state != IDLE);

    assign bus.out_valid = outValid;
    assign bus.out_data  = outValid ? fifoMem[rdPtr] : '0;

    // A late conversion skips WAIT_PERIOD so the next request follows immediately.
    always_comb begin
        afterConv  = WAIT_PERIOD;
        nextState  = state;
        doPush     = 1'b0;
        dropSample = 1'b0;
        timeoutHit = 1'b0;
        if (periodDone) begin
            afterConv = enable ? REQ : IDLE;
        end
        case (state)
            IDLE: begin
                if (enable) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                if (reqCnt == REQ_LAST) begin
                    nextState = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (rdyRise) begin
                    nextState = CAPTURE;
                end else if (waitCnt == TO_LAST) begin
                    timeoutHit = 1'b1;
                    nextState  = afterConv;
                end
            end
            CAPTURE: begin
                if (fifoFull && !doPop) begin
                    dropSample = 1'b1;
                end else begin
                    doPush = 1'b1;
                end
                nextState = afterConv;
            end
            WAIT_PERIOD: begin
                if (periodDone) begin
                    nextState = enable ? REQ : IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // adc_req comes straight from a flop so the ADC never sees a combinational glitch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdyMeta     <= 1'b0;
            rdyS        <= 1'b0;
            rdyPrev     <= 1'b0;
            bus.adc_req <= 1'b0;
            reqCnt      <= '0;
            waitCnt     <= '0;
            periodCnt   <= '0;
        end else begin
            rdyMeta     <= bus.adc_rdy;
            rdyS        <= rdyMeta;
            rdyPrev     <= rdyS;
            bus.adc_req <= (nextState == REQ);
            reqCnt      <= (state == REQ) ? reqCnt + 1'b1 : '0;
            waitCnt     <= (state == WAIT_RDY) ? waitCnt + 1'b1 : '0;
            if (nextState == REQ && state != REQ) begin
                periodCnt <= '0;
            end else if (periodCnt != '1) begin
                periodCnt <= periodCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr] <= bus.adc_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifo_count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A new error event in the same cycle as clear_err keeps its flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
            sample_cnt   <= '0;
        end else begin
            if (timeoutHit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
            if (dropSample) begin
                overflow_err <= 1'b1;
            end else if (clear_err) begin
                overflow_err <= 1'b0;
            end
            if (doPush) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/adc_reader.md
Name: adc_reader

Overview:
- Clocked initiator for the asynchronous ADC request/ready interface; the ADC itself is the responder.
- Periodically pulses adc_req, waits for the ADC's rdy, and captures the 8-bit dat.
- Pushes each sample into a small first-word-fall-through (FWFT) FIFO, drained by downstream logic over a valid/ready stream.
- Flags timeouts and overflows, and counts completed samples.

Parameters:
- DATA_W, 8, ADC sample width.
- FIFO_DEPTH, 8, sample FIFO entries; power of 2, minimum 2.
- REQ_CYCLES, 2, adc_req pulse width in clk cycles; minimum 1.
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT_RDY before abort.
- PERIOD_W, 16, width of the period input.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  run continuous sampling while high.
- period  in  PERIOD_W  cycles between successive request starts; 0 is treated as 1.
- clear_err  in  1  one-cycle pulse; clears the sticky flags.
- adc_req  out  1  request pulse to the ADC.
- adc_rdy  in  1  ADC ready; asynchronous to clk.
- adc_dat  in  DATA_W  ADC data; stable while adc_rdy is high.
- out_valid  out  1  FIFO not empty.
- out_data  out  DATA_W  FIFO head (FWFT).
- out_ready  in  1  consumer accepts the head when high with out_valid.
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky: the ADC failed to respond.
- overflow_err  out  1  sticky: a sample was dropped because the FIFO was full.
- sample_cnt  out  16  samples written to the FIFO; wraps at 16 bits.

Behaviour:
- Reset (rst=0 at a clk edge) drives the following, effective the next cycle even mid-conversion:
  - adc_req=0, out_valid=0, out_data=0, fifo_count=0, busy=0.
  - timeout_err=0, overflow_err=0, sample_cnt=0.
  - FIFO pointers 0, synchroniser flops 0, state IDLE.
- adc_rdy passes through a 2-flop synchroniser (rdy_s). A rising edge is rdy_s=1 with previous rdy_s=0.
- A period counter is cleared on every entry to REQ and then increments each cycle, saturating.
- FSM states: IDLE, REQ, WAIT_RDY, CAPTURE, WAIT_PERIOD.
  - IDLE: enable=1 moves to REQ on the next cycle; the first request is immediate.
  - REQ: adc_req=1 for exactly REQ_CYCLES cycles, then WAIT_RDY. adc_req is registered and glitch-free, and is 0 in every other state.
  - WAIT_RDY: rising edge of rdy_s moves to CAPTURE. If TIMEOUT_CYCLES cycles pass with no edge, set timeout_err and go to WAIT_PERIOD without writing. A rdy that is already high (no edge) is not accepted.
  - CAPTURE (1 cycle): push adc_dat into the FIFO and increment sample_cnt, then go to WAIT_PERIOD. If the FIFO is full with no pop that cycle: drop the sample, set overflow_err, leave sample_cnt unchanged.
  - WAIT_PERIOD: when period counter ≥ max(period,1)−1, go to REQ if enable=1, else IDLE. If the conversion took longer than the period, the next request starts the cycle after CAPTURE or timeout.
- enable falling mid-conversion: the current conversion completes (capture or timeout), then the FSM goes to IDLE. No request is ever truncated.
- Latency: adc_rdy rise to FIFO write is 3–4 clk cycles (synchroniser uncertainty). out_valid rises the cycle after the write.
- FIFO:
  - Pop occurs when out_valid & out_ready.
  - Simultaneous push and pop when full: both happen, count unchanged, no overflow.
  - Simultaneous push and pop when empty: the push lands and out_valid rises next cycle; no pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- clear_err clears both sticky flags. An error event in the same cycle wins: its flag stays 1.
- period changes take effect at the next WAIT_PERIOD comparison.

Test Plan:
1. rst=0 for 2 cycles, enable=1, period=20, ADC model raises rdy 30 ns after req with dat=0x11,0x22,0x33 → three adc_req pulses each exactly 2 cycles wide, starts 20 cycles apart. out_data sequence 0x11,0x22,0x33; sample_cnt=3; no error flags.
2. ADC model never raises rdy, TIMEOUT_CYCLES=64 → timeout_err=1 at cycle 64 of WAIT_RDY, no FIFO write, next req issued per period. After a clear_err pulse, timeout_err=0.
3. out_ready=0, 10 conversions with FIFO_DEPTH=8 → fifo_count=8, overflow_err=1, sample_cnt=8. Then drain with out_ready=1 → the first 8 values come out in order, out_valid=0 after the 8th pop.
4. FIFO full and out_ready=1 held during a CAPTURE → push and pop in the same cycle, fifo_count stays 8, overflow_err stays 0.
5. rst=0 asserted while adc_req=1 mid-pulse → the next cycle has adc_req=0, busy=0, fifo_count=0, and all flags clear.
6. enable dropped during WAIT_RDY; rdy then arrives with dat=0x5A → 0x5A is captured, FSM returns to IDLE, and no further adc_req occurs.
